// File: rtl/cplx_pkg.sv
// Shared definitions for the complex result reader: Q11.21 sample type,
// reader FSM states and the positive saturation limit used by the magnitude path.
package cplx_pkg;

  localparam int SAMPLE_W = 32;

  typedef logic signed [SAMPLE_W-1:0] q11_21_t;

  localparam q11_21_t Q_SAT_MAX = 32'sh7FFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  // |a| + |b| clamped to Q_SAT_MAX; |most negative| is exact as an unsigned magnitude
  function automatic q11_21_t q_abs_sum_sat(input q11_21_t a, input q11_21_t b);
    logic [SAMPLE_W-1:0] ua;
    logic [SAMPLE_W-1:0] ub;
    logic [SAMPLE_W-1:0] mag_a;
    logic [SAMPLE_W-1:0] mag_b;
    logic [SAMPLE_W:0]   sum;
    ua    = a;
    ub    = b;
    mag_a = ua[SAMPLE_W-1] ? (~ua + 32'd1) : ua;
    mag_b = ub[SAMPLE_W-1] ? (~ub + 32'd1) : ub;
    sum   = {1'b0, mag_a} + {1'b0, mag_b};
    if (sum > {1'b0, Q_SAT_MAX}) begin
      q_abs_sum_sat = Q_SAT_MAX;
    end else begin
      q_abs_sum_sat = q11_21_t'(sum[SAMPLE_W-1:0]);
    end
  endfunction

endpackage

// File: rtl/cplx_result_reader_if.sv
// Output element stream of the complex result reader (valid/ready handshake).
// out_mag exists only when RB_MAG_EN is defined.
interface cplx_result_reader_if #(
  parameter int NBIT  = 32,
  parameter int IDX_W = 4
);
  logic                   out_valid;
  logic                   out_ready;
  logic signed [NBIT-1:0] out_real;
  logic signed [NBIT-1:0] out_imag;
  logic [IDX_W-1:0]       out_idx;
  logic                   out_last;
`ifdef RB_MAG_EN
  logic [NBIT-1:0]        out_mag;
`endif

  modport master (
    output out_valid, out_real, out_imag, out_idx, out_last,
`ifdef RB_MAG_EN
    output out_mag,
`endif
    input  out_ready
  );

  modport slave (
    input  out_valid, out_real, out_imag, out_idx, out_last,
`ifdef RB_MAG_EN
    input  out_mag,
`endif
    output out_ready
  );
endinterface

// File: rtl/rb_fifo2.sv
// Two-entry valid/ready FIFO. A simultaneous push and pop leaves occupancy unchanged;
// the head entry is never overwritten, so the output holds steady while stalled.
module rb_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign o_ready = (r_count != 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;
  assign w_push  = i_valid && o_ready;
  assign w_pop   = o_valid && i_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cplx_result_reader.sv
// Reads a DIM x DIM complex result frame from the real/imag RAMs and streams it out
// in row-major order. Define RB_MAG_EN to add a saturated |re|+|im| output (out_mag).
module cplx_result_reader
  import cplx_pkg::*;
#(
  parameter int DIM        = 3,
  parameter int NBIT       = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  input  logic signed [NBIT-1:0] q_real,
  input  logic signed [NBIT-1:0] q_imag,
  cplx_result_reader_if.master   strm
);

  localparam int NELEM  = DIM * DIM;
  localparam int IDX_W  = $clog2(NELEM);
  localparam int OFF_IM = 1 + IDX_W;
  localparam int OFF_RE = OFF_IM + NBIT;
`ifdef RB_MAG_EN
  localparam int OFF_MAG = OFF_RE + NBIT;
  localparam int ENTRY_W = OFF_MAG + NBIT;
`else
  localparam int ENTRY_W = OFF_RE + NBIT;
`endif
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NELEM - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NELEM - 1);

  rd_state_e             r_state;
  rd_state_e             w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_inflight;
  logic [IDX_W-1:0]      r_infl_idx;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_issue;
  logic                  w_frame_end;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_ready;
  logic                  w_fifo_valid;
  logic [1:0]            w_count;
  logic [1:0]            w_occ_eff;
  logic [ENTRY_W-1:0]    w_push_data;
  logic [ENTRY_W-1:0]    w_head;

  // Entry packing: {mag?, real, imag, idx, last}; last is decided at push time
`ifdef RB_MAG_EN
  logic [NBIT-1:0] w_push_mag;
  assign w_push_mag  = NBIT'(q_abs_sum_sat(q11_21_t'(q_real), q11_21_t'(q_imag)));
  assign w_push_data = {w_push_mag, q_real, q_imag, r_infl_idx, (r_infl_idx == LAST_IDX)};
  assign strm.out_mag = w_head[OFF_MAG +: NBIT];
`else
  assign w_push_data = {q_real, q_imag, r_infl_idx, (r_infl_idx == LAST_IDX)};
`endif

  assign w_push    = r_inflight && w_fifo_ready;
  assign w_pop     = w_fifo_valid && strm.out_ready;
  // A pop this cycle frees a slot in time for the read issued now
  assign w_occ_eff = w_count - {1'b0, w_pop};

  rb_fifo2 #(.W(ENTRY_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_push),
    .o_ready (w_fifo_ready),
    .i_data  (w_push_data),
    .o_valid (w_fifo_valid),
    .i_ready (strm.out_ready),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign strm.out_valid = w_fifo_valid;
  assign strm.out_last  = w_head[0];
  assign strm.out_idx   = w_head[1 +: IDX_W];
  assign strm.out_imag  = w_head[OFF_IM +: NBIT];
  assign strm.out_real  = w_head[OFF_RE +: NBIT];
  assign ram_addr       = r_addr;
  assign busy           = r_busy;
  assign done           = r_done;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, read issue and end-of-frame detection
  always_comb begin
    w_next      = r_state;
    w_issue     = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = ST_RUN;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (({1'b0, w_occ_eff} + {2'b00, r_inflight}) < 3'd2) begin
          w_issue = 1'b1;
          if (r_addr == LAST_ADDR) begin
            w_next = ST_DRAIN;
          end else begin
            w_next = ST_RUN;
          end
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (w_pop && w_head[0]) begin
          w_next      = ST_IDLE;
          w_frame_end = 1'b1;
        end else begin
          w_next = ST_DRAIN;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Address counter, in-flight tracking and status flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr     <= '0;
      r_inflight <= 1'b0;
      r_infl_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_infl_idx <= IDX_W'(r_addr);
      end else begin
        r_infl_idx <= r_infl_idx;
      end
      if ((r_state == ST_IDLE) && start) begin
        r_addr <= '0;
      end else if (w_issue && (r_addr != LAST_ADDR)) begin
        r_addr <= r_addr + 1'b1;
      end else begin
        r_addr <= r_addr;
      end
      r_busy <= (w_next != ST_IDLE);
      r_done <= w_frame_end;
    end
  end

endmodule

// File: tb/tb_cplx_result_reader.sv
// Self-checking bench for cplx_result_reader: randomized RAM contents and sink
// backpressure compared against a frame-level reference (element k = RAM[k]).
module tb_cplx_result_reader;

  localparam int DIM  = 3;
  localparam int NBIT = 32;
  localparam int AW   = 4;
  localparam int NE   = DIM * DIM;
  localparam int IDXW = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic [AW-1:0]          ram_addr;
  logic signed [NBIT-1:0] q_real;
  logic signed [NBIT-1:0] q_imag;

  logic [NBIT-1:0] mem_re [16];
  logic [NBIT-1:0] mem_im [16];

  int checks = 0;
  int errors = 0;

  logic [NBIT-1:0] g_re [$];
  logic [NBIT-1:0] g_im [$];
  int              g_idx [$];
  int              g_last [$];
  int              g_k [$];
`ifdef RB_MAG_EN
  logic [NBIT-1:0] g_mag [$];
`endif
  int g_done_cnt;
  int g_done_k;
  int g_busy_at_done;
  int g_busy_k0;
  int g_stall_err;
  int g_addr_k9;

  cplx_result_reader_if #(.NBIT(NBIT), .IDX_W(IDXW)) strm ();

  cplx_result_reader #(.DIM(DIM), .NBIT(NBIT), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .ram_addr (ram_addr),
    .q_real   (q_real),
    .q_imag   (q_imag),
    .strm     (strm)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM pair: data one clock after the address
  always @(posedge clk) begin
    q_real <= mem_re[ram_addr];
    q_imag <= mem_im[ram_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic fill_ramp();
    for (int i = 0; i < 16; i++) begin
      mem_re[i] = 32'(i);
      mem_im[i] = 32'(-i);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      mem_re[i] = $urandom;
      mem_im[i] = $urandom;
    end
  endtask

  // Pulse start for one clock; returns at the sample point of cycle 0 after acceptance
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives out_ready per mode and records every handshake until done or nmax cycles.
  // mode 0: always ready, 1: toggle 1,0,..., 2: stalled for 10 cycles, else random.
  task automatic collect(input int mode, input int nmax, input int start_at);
    logic            pv;
    logic            pr;
    logic [NBIT-1:0] p_re;
    logic [NBIT-1:0] p_im;
    logic [IDXW-1:0] p_idx;
    logic            p_last;
    g_re.delete(); g_im.delete(); g_idx.delete(); g_last.delete(); g_k.delete();
`ifdef RB_MAG_EN
    g_mag.delete();
`endif
    g_done_cnt = 0; g_done_k = -1; g_busy_at_done = -1; g_busy_k0 = -1;
    g_stall_err = 0; g_addr_k9 = -1;
    pv = 1'b0; pr = 1'b1; p_re = '0; p_im = '0; p_idx = '0; p_last = 1'b0;
    for (int k = 0; k < nmax; k++) begin
      case (mode)
        0:       strm.out_ready = 1'b1;
        1:       strm.out_ready = ((k % 2) == 0);
        2:       strm.out_ready = (k >= 10);
        default: strm.out_ready = ($urandom_range(0, 1) == 1);
      endcase
      start = (k == start_at);
      if (k == 0) g_busy_k0 = int'(busy);
      if (k == 9) g_addr_k9 = int'(ram_addr);
      if (pv && !pr && (strm.out_valid !== 1'b1 || strm.out_real !== p_re ||
          strm.out_imag !== p_im || strm.out_idx !== p_idx || strm.out_last !== p_last))
        g_stall_err++;
      if (strm.out_valid === 1'b1 && strm.out_ready === 1'b1) begin
        g_re.push_back(strm.out_real);
        g_im.push_back(strm.out_imag);
        g_idx.push_back(int'(strm.out_idx));
        g_last.push_back(int'(strm.out_last));
        g_k.push_back(k);
`ifdef RB_MAG_EN
        g_mag.push_back(strm.out_mag);
`endif
      end
      if (done === 1'b1) begin
        g_done_cnt++;
        g_done_k = k;
        g_busy_at_done = int'(busy);
        break;
      end
      pv = strm.out_valid; pr = strm.out_ready;
      p_re = strm.out_real; p_im = strm.out_imag; p_idx = strm.out_idx; p_last = strm.out_last;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  // Reference: the stream must be exactly RAM[0..NE-1] with idx k and last on NE-1
  function automatic int stream_errors();
    int n = 0;
    if (g_re.size() != NE) n++;
    for (int i = 0; i < g_re.size(); i++) begin
      if (i >= NE) n++;
      else if (g_re[i] !== mem_re[i] || g_im[i] !== mem_im[i] || g_idx[i] != i ||
               g_last[i] != ((i == NE - 1) ? 1 : 0)) n++;
    end
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; strm.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || strm.out_valid !== 1'b0 || ram_addr !== 4'd0 ||
        strm.out_idx !== 4'd0 || strm.out_last !== 1'b0 || strm.out_real !== 32'd0 ||
        strm.out_imag !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b valid=%b addr=%0d idx=%0d last=%b re=%h im=%h, required all 0",
               busy, done, strm.out_valid, ram_addr, strm.out_idx, strm.out_last, strm.out_real, strm.out_imag);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    fill_ramp();
    do_start();
    collect(0, 40, -1);
    checks++;
    if (g_busy_k0 != 1) begin
      errors++; $display("FAIL basic_busy: busy=%0d after start, required 1", g_busy_k0);
    end
    checks++;
    if (g_re.size() != NE) begin
      errors++; $display("FAIL basic_count: got %0d elements, required %0d", g_re.size(), NE);
    end
    for (int i = 0; i < NE; i++) begin
      checks++;
      if (i >= g_re.size()) begin
        errors++; $display("FAIL basic_elem%0d: missing, required re=%0d", i, i);
      end else if (g_re[i] !== 32'(i) || g_im[i] !== 32'(-i) || g_idx[i] != i ||
                   g_last[i] != ((i == NE - 1) ? 1 : 0) || g_k[i] != i + 2) begin
        errors++;
        $display("FAIL basic_elem%0d: re=%0d im=%0d idx=%0d last=%0d cycle=%0d, required re=%0d im=%0d idx=%0d last=%0d cycle=%0d",
                 i, $signed(g_re[i]), $signed(g_im[i]), g_idx[i], g_last[i], g_k[i],
                 i, -i, i, (i == NE - 1) ? 1 : 0, i + 2);
      end
    end
    checks++;
    if (g_done_cnt != 1 || g_done_k != NE + 2 || g_busy_at_done != 0) begin
      errors++;
      $display("FAIL basic_done: pulses=%0d cycle=%0d busy=%0d, required 1 at cycle %0d with busy 0",
               g_done_cnt, g_done_k, g_busy_at_done, NE + 2);
    end
  endtask

  task automatic test_toggle();
    int n;
    fill_random();
    do_start();
    collect(1, 60, -1);
    n = stream_errors();
    checks++;
    if (n != 0) begin errors++; $display("FAIL toggle_stream: %0d bad elements, required 0", n); end
    checks++;
    if (g_stall_err != 0) begin errors++; $display("FAIL toggle_stable: %0d stall changes, required 0", g_stall_err); end
    checks++;
    if (g_done_cnt != 1) begin errors++; $display("FAIL toggle_done: pulses=%0d, required 1", g_done_cnt); end
  endtask

  task automatic test_backpressure();
    int n;
    fill_random();
    do_start();
    collect(2, 60, -1);
    checks++;
    if (g_addr_k9 != 2) begin errors++; $display("FAIL stall_addr: ram_addr=%0d while stalled, required 2", g_addr_k9); end
    n = stream_errors();
    checks++;
    if (n != 0) begin errors++; $display("FAIL stall_stream: %0d bad elements, required 0", n); end
    checks++;
    if (g_stall_err != 0 || g_done_cnt != 1) begin
      errors++; $display("FAIL stall_hold: changes=%0d done=%0d, required 0 and 1", g_stall_err, g_done_cnt);
    end
  endtask

  task automatic test_restart_ignored();
    int n;
    int extra;
    fill_random();
    do_start();
    collect(3, 80, 4);
    n = stream_errors();
    checks++;
    if (n != 0 || g_done_cnt != 1) begin
      errors++; $display("FAIL restart_stream: bad=%0d done=%0d, required 0 and 1", n, g_done_cnt);
    end
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1 || strm.out_valid === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL restart_extra: %0d active cycles after done, required 0", extra); end
  endtask

  task automatic test_back_to_back();
    int n;
    fill_random();
    do_start();
    collect(0, 40, -1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy=%b, required 1", busy); end
    collect(3, 80, -1);
    n = stream_errors();
    checks++;
    if (n != 0 || g_done_cnt != 1) begin
      errors++; $display("FAIL b2b_stream: bad=%0d done=%0d, required 0 and 1", n, g_done_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    int found;
    int seen;
    int n;
    fill_random();
    do_start();
    strm.out_ready = 1'b1;
    found = 0;
    for (int k = 0; k < 30; k++) begin
      if (strm.out_valid === 1'b1 && strm.out_idx === 4'd4) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (found == 0) begin errors++; $display("FAIL midrst_reach: element 4 seen=%0d, required 1", found); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (strm.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ram_addr !== 4'd0 ||
        strm.out_idx !== 4'd0 || strm.out_real !== 32'd0) begin
      errors++;
      $display("FAIL midrst_clear: valid=%b busy=%b done=%b addr=%0d idx=%0d re=%h, required all 0",
               strm.out_valid, busy, done, ram_addr, strm.out_idx, strm.out_real);
    end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || strm.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midrst_quiet: %0d cycles with done/valid, required 0", seen); end
    fill_random();
    do_start();
    collect(3, 80, -1);
    n = stream_errors();
    checks++;
    if (n != 0 || g_done_cnt != 1) begin
      errors++; $display("FAIL midrst_refill: bad=%0d done=%0d, required 0 and 1", n, g_done_cnt);
    end
  endtask

  task automatic test_random_frames();
    int n;
    for (int f = 0; f < 4; f++) begin
      fill_random();
      do_start();
      collect(3, 100, -1);
      n = stream_errors();
      checks++;
      if (n != 0 || g_done_cnt != 1 || g_stall_err != 0) begin
        errors++;
        $display("FAIL random_frame%0d: bad=%0d done=%0d changes=%0d, required 0, 1, 0",
                 f, n, g_done_cnt, g_stall_err);
      end
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end
  endtask

`ifdef RB_MAG_EN
  function automatic logic [NBIT-1:0] ref_mag(input logic [NBIT-1:0] re, input logic [NBIT-1:0] im);
    longint a;
    longint b;
    a = longint'($signed(re));
    b = longint'($signed(im));
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    if (a + b > 64'sd2147483647) return 32'h7FFF_FFFF;
    return 32'(a + b);
  endfunction

  task automatic test_mag();
    int bad;
    fill_random();
    mem_re[0] = 32'h7FFF_FFFF; mem_im[0] = 32'h0000_0001;
    mem_re[1] = 32'hFFFF_FFFB; mem_im[1] = 32'h0000_0003;
    mem_re[2] = 32'h8000_0000; mem_im[2] = 32'h0000_0000;
    do_start();
    collect(0, 40, -1);
    checks++;
    if (g_mag.size() < 2 || g_mag[0] !== 32'h7FFF_FFFF || g_mag[1] !== 32'd8) begin
      errors++; $display("FAIL mag_sat: first magnitudes wrong, required 7fffffff and 8");
    end
    bad = 0;
    for (int i = 0; i < g_mag.size(); i++)
      if (i < NE && g_mag[i] !== ref_mag(mem_re[i], mem_im[i])) bad++;
    checks++;
    if (bad != 0 || g_mag.size() != NE) begin
      errors++; $display("FAIL mag_all: %0d bad of %0d, required 0 of %0d", bad, g_mag.size(), NE);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_backpressure();
    test_restart_ignored();
    test_back_to_back();
    test_reset_midframe();
    test_random_frames();
`ifdef RB_MAG_EN
    test_mag();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
